// File: rtl/fifo_uart_tx.sv
// Serial transmit stage behind a registered-read FIFO: pops one byte per frame and
// shifts it out as start bit, DATA_W data bits LSB first, optional even parity, stop bit.
module fifo_uart_tx #(
  parameter int CLKS_PER_BIT = 16,
  parameter int DATA_W       = 8,
  parameter int PARITY_EN    = 0
) (
  input  logic              clk,
  input  logic              rst_n0,
  input  logic [DATA_W-1:0] fifo_data0,
  input  logic              fifo_empty0,
  output logic              fifo_read_enable0,
  input  logic              enable0,
  output logic              tx0,
  output logic              busy0,
  output logic [15:0]       bytes_sent0
);

  localparam int BAUD_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int BIT_W  = (DATA_W > 1) ? $clog2(DATA_W) : 1;
  localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);
  localparam logic [BIT_W-1:0]  BIT_LAST  = BIT_W'(DATA_W - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_POP,
    S_LOAD,
    S_START,
    S_DATA,
    S_PARITY,
    S_STOP
  } state_t;

  state_t            state_q, state_d;
  logic [BAUD_W-1:0] baud_q, baud_d;
  logic [BIT_W-1:0]  bit_q, bit_d;
  logic [DATA_W-1:0] shift_q, shift_d;
  logic              parity_q, parity_d;
  logic [15:0]       sent_q, sent_d;
  logic              tx_q, tx_d;
  logic              rd_q, rd_d;
  logic              busy_q, busy_d;
  logic              baud_last;

  always_comb begin
    state_d   = state_q;
    baud_d    = baud_q;
    bit_d     = bit_q;
    shift_d   = shift_q;
    parity_d  = parity_q;
    sent_d    = sent_q;
    baud_last = (baud_q == BAUD_LAST);

    case (state_q)
      S_IDLE: begin
        if (enable0 && !fifo_empty0) begin
          state_d = S_POP;
        end
      end
      S_POP: begin
        state_d = S_LOAD;
      end
      S_LOAD: begin
        shift_d  = fifo_data0;
        parity_d = ^fifo_data0;
        state_d  = S_START;
      end
      S_START: begin
        if (baud_last) begin
          state_d = S_DATA;
        end
      end
      S_DATA: begin
        if (baud_last) begin
          shift_d = shift_q >> 1;
          if (bit_q == BIT_LAST) begin
            bit_d   = '0;
            state_d = (PARITY_EN != 0) ? S_PARITY : S_STOP;
          end else begin
            bit_d = bit_q + 1'b1;
          end
        end
      end
      S_PARITY: begin
        if (baud_last) begin
          state_d = S_STOP;
        end
      end
      S_STOP: begin
        if (baud_last) begin
          sent_d  = sent_q + 16'd1;
          state_d = S_IDLE;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    // Baud counter restarts on every state change; it also wraps between data bits.
    if (state_d != state_q) begin
      baud_d = '0;
    end else if (state_q == S_START || state_q == S_DATA ||
                 state_q == S_PARITY || state_q == S_STOP) begin
      baud_d = baud_last ? '0 : baud_q + 1'b1;
    end

    // Outputs are decoded from the next state so they leave the flops glitch-free.
    rd_d   = (state_d == S_POP);
    busy_d = (state_d != S_IDLE);
    case (state_d)
      S_START:  tx_d = 1'b0;
      S_DATA:   tx_d = shift_d[0];
      S_PARITY: tx_d = parity_d;
      default:  tx_d = 1'b1;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n0) begin
    if (!rst_n0) begin
      state_q  <= S_IDLE;
      baud_q   <= '0;
      bit_q    <= '0;
      shift_q  <= '0;
      parity_q <= 1'b0;
      sent_q   <= '0;
      tx_q     <= 1'b1;
      rd_q     <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      baud_q   <= baud_d;
      bit_q    <= bit_d;
      shift_q  <= shift_d;
      parity_q <= parity_d;
      sent_q   <= sent_d;
      tx_q     <= tx_d;
      rd_q     <= rd_d;
      busy_q   <= busy_d;
    end
  end

  assign tx0               = tx_q;
  assign fifo_read_enable0 = rd_q;
  assign busy0             = busy_q;
  assign bytes_sent0       = sent_q;

endmodule

// File: tb/tb_fifo_uart_tx.sv
// Bench for fifo_uart_tx: two instances (parity off / on) fed by queue-based FIFO models,
// per-cycle traces compared against a frame-level reference built from the byte list.
module tb_fifo_uart_tx;

  localparam int CPB = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n = 1'b1;
  logic [7:0]  fd_a, fd_b;
  logic        emp_a = 1'b1, emp_b = 1'b1;
  logic        rd_a, rd_b, tx_a, tx_b, busy_a, busy_b;
  logic        en_a = 1'b0, en_b = 1'b0;
  logic [15:0] cnt_a, cnt_b;

  fifo_uart_tx #(.CLKS_PER_BIT(CPB), .DATA_W(8), .PARITY_EN(0)) u_dut_a (
    .clk(clk), .rst_n0(rst_n), .fifo_data0(fd_a), .fifo_empty0(emp_a),
    .fifo_read_enable0(rd_a), .enable0(en_a), .tx0(tx_a), .busy0(busy_a),
    .bytes_sent0(cnt_a)
  );

  fifo_uart_tx #(.CLKS_PER_BIT(CPB), .DATA_W(8), .PARITY_EN(1)) u_dut_b (
    .clk(clk), .rst_n0(rst_n), .fifo_data0(fd_b), .fifo_empty0(emp_b),
    .fifo_read_enable0(rd_b), .enable0(en_b), .tx0(tx_b), .busy0(busy_b),
    .bytes_sent0(cnt_b)
  );

  // FIFO models: registered read data, registered empty flag.
  logic [7:0] fq_a[$], fq_b[$];
  logic [7:0] ld_buf[8];
  int         ld_n = 0;
  logic       ld_a = 1'b0, ld_b = 1'b0, clr = 1'b0;
  int         underflow_a = 0, underflow_b = 0;

  always @(posedge clk) begin
    if (clr) fq_a.delete();
    if (rd_a) begin
      if (fq_a.size() == 0) underflow_a <= underflow_a + 1;
      else fd_a <= fq_a.pop_front();
    end
    if (ld_a) for (int i = 0; i < ld_n; i++) fq_a.push_back(ld_buf[i]);
    emp_a <= (fq_a.size() == 0);
  end

  always @(posedge clk) begin
    if (clr) fq_b.delete();
    if (rd_b) begin
      if (fq_b.size() == 0) underflow_b <= underflow_b + 1;
      else fd_b <= fq_b.pop_front();
    end
    if (ld_b) for (int i = 0; i < ld_n; i++) fq_b.push_back(ld_buf[i]);
    emp_b <= (fq_b.size() == 0);
  end

  // Per-cycle trace, each sample is {tx, read_enable, busy}.
  logic [2:0] tr_a[$], tr_b[$];
  logic       rec = 1'b0;

  always @(negedge clk) begin
    if (rec) begin
      tr_a.push_back({tx_a, rd_a, busy_a});
      tr_b.push_back({tx_b, rd_b, busy_b});
    end
  end

  int vecs = 0;
  int errs = 0;

  logic [7:0] mb[$];
  logic [2:0] exp_q[$];

  // Reference: each byte costs a pop cycle, a load cycle and a frame, with one idle
  // cycle between consecutive frames; everything else is idle.
  task automatic model_run(input bit par, input int n);
    logic [7:0] b;
    logic       lv;
    int         ones;
    exp_q.delete();
    foreach (mb[k]) begin
      if (k > 0) exp_q.push_back(3'b100);
      exp_q.push_back(3'b111);
      exp_q.push_back(3'b101);
      b    = mb[k];
      ones = 0;
      for (int s = 0; s < 11; s++) begin
        if (s == 0) lv = 1'b0;
        else if (s <= 8) begin
          lv   = b[s-1];
          ones = ones + int'(b[s-1]);
        end else if (s == 9) begin
          if (!par) continue;
          lv = ((ones % 2) == 1);
        end else lv = 1'b1;
        repeat (CPB) exp_q.push_back({lv, 1'b0, 1'b1});
      end
    end
    while (exp_q.size() < n) exp_q.push_back(3'b100);
  endtask

  function automatic logic [2:0] smp(input bit p, input int i);
    if (p) return (i < tr_b.size()) ? tr_b[i] : 3'bxxx;
    return (i < tr_a.size()) ? tr_a[i] : 3'bxxx;
  endfunction

  task automatic load(input bit p);
    @(negedge clk);
    ld_n = mb.size();
    foreach (mb[i]) ld_buf[i] = mb[i];
    if (p) ld_b = 1'b1; else ld_a = 1'b1;
    @(negedge clk);
    ld_a = 1'b0;
    ld_b = 1'b0;
  endtask

  task automatic record(input int n);
    tr_a.delete();
    tr_b.delete();
    #1 rec = 1'b1;
    repeat (n) @(negedge clk);
    #1 rec = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    clr   = 1'b1;
    en_a  = 1'b0;
    en_b  = 1'b0;
    @(negedge clk);
    clr = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    #2 rst_n = 1'b0;
    en_a = 1'b1;
    en_b = 1'b1;
    mb = '{8'h11, 8'h22, 8'h33};
    load(0);
    load(1);
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      vecs++;
      if ({tx_a, rd_a, busy_a, cnt_a} !== {3'b100, 16'h0000}) begin
        errs++;
        $display("FAIL reset_a[%0d]: tx/rd/busy/count=%b/%0d, expected 100/0", c, {tx_a, rd_a, busy_a}, cnt_a);
      end
      vecs++;
      if ({tx_b, rd_b, busy_b, cnt_b} !== {3'b100, 16'h0000}) begin
        errs++;
        $display("FAIL reset_b[%0d]: tx/rd/busy/count=%b/%0d, expected 100/0", c, {tx_b, rd_b, busy_b}, cnt_b);
      end
    end
  endtask

  task automatic test_single();
    int busy_n, rd_n;
    do_reset();
    en_a = 1'b1;
    mb = '{8'hA5};
    load(0);
    record(50);
    model_run(0, 50);
    busy_n = 0;
    rd_n   = 0;
    for (int i = 0; i < 50; i++) begin
      busy_n += int'(smp(0, i)[0]);
      rd_n   += int'(smp(0, i)[1]);
      vecs++;
      if (smp(0, i) !== exp_q[i]) begin
        errs++;
        $display("FAIL single_trace[%0d]: tx/rd/busy=%b, expected %b", i, smp(0, i), exp_q[i]);
      end
    end
    vecs++;
    if (busy_n !== 42) begin errs++; $display("FAIL single_busy_len: got %0d, expected 42", busy_n); end
    vecs++;
    if (rd_n !== 1) begin errs++; $display("FAIL single_read_pulses: got %0d, expected 1", rd_n); end
    vecs++;
    if (cnt_a !== 16'd1) begin errs++; $display("FAIL single_count: got %0d, expected 1", cnt_a); end
    vecs++;
    if (emp_a !== 1'b1 || busy_a !== 1'b0) begin
      errs++;
      $display("FAIL single_idle_empty: empty=%b busy=%b, expected 1 0", emp_a, busy_a);
    end
  endtask

  task automatic test_back_to_back();
    int i, gap;
    do_reset();
    en_a = 1'b1;
    mb = '{8'h00, 8'hFF};
    load(0);
    record(95);
    model_run(0, 95);
    for (int k = 0; k < 95; k++) begin
      vecs++;
      if (smp(0, k) !== exp_q[k]) begin
        errs++;
        $display("FAIL b2b_trace[%0d]: tx/rd/busy=%b, expected %b", k, smp(0, k), exp_q[k]);
      end
    end
    i   = 0;
    gap = 0;
    while (i < tr_a.size() && tr_a[i][2]) i++;
    while (i < tr_a.size() && !tr_a[i][2]) i++;
    while (i < tr_a.size() && tr_a[i][2]) begin gap++; i++; end
    vecs++;
    if (gap !== CPB + 3) begin errs++; $display("FAIL b2b_gap: got %0d high cycles, expected %0d", gap, CPB + 3); end
    vecs++;
    if (cnt_a !== 16'd2) begin errs++; $display("FAIL b2b_count: got %0d, expected 2", cnt_a); end
  endtask

  task automatic test_parity();
    int run, first_low;
    do_reset();
    en_b = 1'b1;
    mb = '{8'h07, 8'h03};
    load(1);
    record(100);
    model_run(1, 100);
    for (int k = 0; k < 100; k++) begin
      vecs++;
      if (smp(1, k) !== exp_q[k]) begin
        errs++;
        $display("FAIL parity_trace[%0d]: tx/rd/busy=%b, expected %b", k, smp(1, k), exp_q[k]);
      end
    end
    run = 0;
    while (run < tr_b.size() && tr_b[run][0]) run++;
    first_low = 0;
    while (first_low < tr_b.size() && tr_b[first_low][2]) first_low++;
    vecs++;
    if (run - first_low !== 44) begin
      errs++;
      $display("FAIL parity_frame_len: got %0d, expected 44", run - first_low);
    end
    vecs++;
    if (smp(1, 2 + 9 * CPB + 1) !== 3'b101) begin
      errs++;
      $display("FAIL parity_bit_07: got %b, expected 101", smp(1, 2 + 9 * CPB + 1));
    end
    vecs++;
    if (smp(1, 49 + 9 * CPB + 1) !== 3'b001) begin
      errs++;
      $display("FAIL parity_bit_03: got %b, expected 001", smp(1, 49 + 9 * CPB + 1));
    end
    vecs++;
    if (cnt_b !== 16'd2) begin errs++; $display("FAIL parity_count: got %0d, expected 2", cnt_b); end
  endtask

  task automatic test_enable();
    do_reset();
    mb = '{8'h3C, 8'hC3, 8'h5A};
    load(0);
    record(20);
    for (int k = 0; k < 20; k++) begin
      vecs++;
      if (smp(0, k) !== 3'b100) begin
        errs++;
        $display("FAIL enable_off[%0d]: tx/rd/busy=%b, expected 100", k, smp(0, k));
      end
    end
    vecs++;
    if (fq_a.size() !== 3) begin errs++; $display("FAIL enable_off_fifo: got %0d entries, expected 3", fq_a.size()); end
    en_a = 1'b1;
    tr_a.delete();
    tr_b.delete();
    rec = 1'b1;
    repeat (10) @(negedge clk);
    en_a = 1'b0;
    repeat (40) @(negedge clk);
    #1 rec = 1'b0;
    mb = '{8'h3C};
    model_run(0, 50);
    for (int k = 0; k < 50; k++) begin
      vecs++;
      if (smp(0, k) !== exp_q[k]) begin
        errs++;
        $display("FAIL enable_drop_trace[%0d]: tx/rd/busy=%b, expected %b", k, smp(0, k), exp_q[k]);
      end
    end
    vecs++;
    if (fq_a.size() !== 2) begin errs++; $display("FAIL enable_drop_fifo: got %0d entries, expected 2", fq_a.size()); end
    vecs++;
    if (cnt_a !== 16'd1) begin errs++; $display("FAIL enable_drop_count: got %0d, expected 1", cnt_a); end
  endtask

  task automatic test_reset_mid();
    logic [7:0] b1, b2;
    do_reset();
    en_a = 1'b1;
    b1 = 8'($urandom);
    b2 = 8'($urandom);
    mb = '{b1, b2};
    load(0);
    tr_a.delete();
    tr_b.delete();
    #1 rec = 1'b1;
    repeat (20) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    vecs++;
    if ({tx_a, rd_a, busy_a, cnt_a} !== {3'b100, 16'h0000}) begin
      errs++;
      $display("FAIL reset_mid_async: tx/rd/busy/count=%b/%0d, expected 100/0", {tx_a, rd_a, busy_a}, cnt_a);
    end
    rec = 1'b0;
    mb = '{b1};
    model_run(0, 20);
    for (int k = 0; k < 20; k++) begin
      vecs++;
      if (smp(0, k) !== exp_q[k]) begin
        errs++;
        $display("FAIL reset_mid_pre[%0d]: tx/rd/busy=%b, expected %b", k, smp(0, k), exp_q[k]);
      end
    end
    repeat (2) @(negedge clk);
    vecs++;
    if (fq_a.size() !== 1) begin errs++; $display("FAIL reset_mid_fifo: got %0d entries, expected 1", fq_a.size()); end
    rst_n = 1'b1;
    mb = '{b2};
    record(50);
    model_run(0, 50);
    for (int k = 0; k < 50; k++) begin
      vecs++;
      if (smp(0, k) !== exp_q[k]) begin
        errs++;
        $display("FAIL reset_mid_post[%0d]: tx/rd/busy=%b, expected %b", k, smp(0, k), exp_q[k]);
      end
    end
    vecs++;
    if (cnt_a !== 16'd1) begin errs++; $display("FAIL reset_mid_count: got %0d, expected 1", cnt_a); end
  endtask

  task automatic test_random();
    bit p;
    int nb;
    for (int it = 0; it < 4; it++) begin
      p = it[0];
      do_reset();
      if (p) en_b = 1'b1; else en_a = 1'b1;
      nb = $urandom_range(1, 4);
      mb.delete();
      for (int k = 0; k < nb; k++) mb.push_back(8'($urandom));
      load(p);
      record(200);
      model_run(p, 200);
      for (int k = 0; k < 200; k++) begin
        vecs++;
        if (smp(p, k) !== exp_q[k]) begin
          errs++;
          $display("FAIL random%0d_trace[%0d]: tx/rd/busy=%b, expected %b", it, k, smp(p, k), exp_q[k]);
        end
      end
      vecs++;
      if ((p ? cnt_b : cnt_a) !== 16'(nb)) begin
        errs++;
        $display("FAIL random%0d_count: got %0d, expected %0d", it, p ? cnt_b : cnt_a, nb);
      end
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_parity();
    test_enable();
    test_reset_mid();
    test_random();
    vecs++;
    if (underflow_a !== 0 || underflow_b !== 0) begin
      errs++;
      $display("FAIL pop_while_empty: got %0d/%0d, expected 0/0", underflow_a, underflow_b);
    end
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule

// File: doc/fifo_uart_tx.md
Name: fifo_uart_tx

Overview:
- Serial transmit stage directly downstream of the 8-bit, depth-8 synchronous FIFO.
- Pops bytes from the FIFO read port and shifts each one out as an asynchronous serial frame: start bit, 8 data bits LSB first, optional even parity bit, 1 stop bit.
- Honours the FIFO's registered read timing: read data becomes valid the cycle after the read-enable cycle.

Parameters:
CLKS_PER_BIT, 16, clock cycles per serial bit; legal values are 2 and above.
DATA_W, 8, byte width; must match the FIFO width.
PARITY_EN, 0, 1 inserts an even parity bit after the data bits.

Ports:
clk  input  1  system clock; all logic on its rising edge.
rst_n0  input  1  asynchronous, active-low reset.
fifo_data0  input  DATA_W  FIFO read data; valid the cycle after fifo_read_enable0 is high.
fifo_empty0  input  1  FIFO empty flag.
fifo_read_enable0  output  1  one-cycle pop request to the FIFO.
enable0  input  1  transmitter enable.
tx0  output  1  serial line; idle level is 1.
busy0  output  1  high whenever the state is not IDLE.
bytes_sent0  output  16  count of completed frames; wraps modulo 2^16.

Behaviour:
- Clock and reset: one clock (clk). Reset is asynchronous, active-low (rst_n0).
- While rst_n0 = 0, all outputs take their reset values immediately:
  - tx0 = 1, fifo_read_enable0 = 0, busy0 = 0, bytes_sent0 = 0.
  - State = IDLE; shift register, bit counter and baud counter = 0.
- State machine: IDLE -> POP -> LOAD -> START -> DATA -> [PARITY] -> STOP -> IDLE.
- IDLE:
  - tx0 = 1.
  - Goes to POP on the next edge only if enable0 = 1 and fifo_empty0 = 0.
  - fifo_empty0 and enable0 are sampled only in IDLE.
- POP: exactly 1 cycle. fifo_read_enable0 = 1 in this state only; it is a registered-state decode, glitch-free.
- LOAD: exactly 1 cycle. fifo_data0 is captured into the shift register at the end of the cycle; the parity bit is computed from the same captured byte.
- START: tx0 = 0 for CLKS_PER_BIT cycles.
- DATA:
  - DATA_W bits, LSB first, each held for CLKS_PER_BIT cycles.
  - Bit counter runs 0 to DATA_W-1.
- PARITY (only when PARITY_EN = 1): tx0 = XOR of the data bits (even parity) for CLKS_PER_BIT cycles.
- STOP:
  - tx0 = 1 for CLKS_PER_BIT cycles.
  - bytes_sent0 increments on the last STOP cycle.
  - Then always returns to IDLE.
- Baud counter: counts 0 to CLKS_PER_BIT-1 and resets to 0 on every state change.
- Frame length: (2 + DATA_W + PARITY_EN) * CLKS_PER_BIT cycles.
- Back-to-back frames: tx0 is held at 1 for 3 extra cycles (IDLE, POP, LOAD) between the end of STOP and the next START.
- No pop is ever issued while fifo_empty0 = 1; an empty FIFO parks the block in IDLE.
- enable0 dropping mid-frame: the current frame completes; no further pop follows.
- Reset mid-frame:
  - tx0 returns to 1 immediately; the partial byte is discarded.
  - The FIFO entry already popped is lost and is not retried.
- tx0 is driven from a register; there is no combinational path from inputs to tx0.

Test Plan:
- Reset: rst_n0 = 0 for 3 cycles with a non-empty FIFO -> tx0 = 1, busy0 = 0, fifo_read_enable0 = 0, bytes_sent0 = 0 throughout.
- Single byte, CLKS_PER_BIT = 4, PARITY_EN = 0, FIFO holds 0xA5, enable0 = 1:
  - Exactly one 1-cycle read pulse.
  - tx0: 0 for 4 cycles, then bits 1,0,1,0,0,1,0,1 at 4 cycles each, then 1 for 4 cycles.
  - bytes_sent0 = 1; busy0 high for 42 cycles; then IDLE with the FIFO empty.
- Back-to-back, FIFO holds 0x00 then 0xFF:
  - Two frames; tx0 high for exactly 4 + 3 cycles between the last data bit of frame 1 and the start bit of frame 2.
  - bytes_sent0 = 2.
- Parity, PARITY_EN = 1, byte 0x07 -> parity bit = 1; byte 0x03 -> parity bit = 0. Frame length is 44 cycles at CLKS_PER_BIT = 4.
- Enable gating:
  - enable0 = 0 with the FIFO holding 3 bytes -> no read pulse, tx0 = 1.
  - enable0 dropped during the DATA state of frame 1 -> frame 1 completes, no second pop, bytes_sent0 = 1.
- Reset mid-DATA, asserted during bit 3 -> tx0 = 1 and busy0 = 0 in the same cycle. After release with 1 byte left, a fresh full frame of the next byte is sent; bytes_sent0 = 1.
